// File: rtl/sha256_msg_padder_pkg.sv
// Shared SHA-256 definitions for the message padder.
//   SHA256_BLOCK_WORDS : 64-bit words per 512-bit block
//   SHA256_PAD_BYTE    : terminator byte appended after the message
//   SHA256_LEN_W       : width of the trailing message bit-length field
//   pad_state_t        : padder FSM states
package sha256_msg_padder_pkg;

  localparam int          SHA256_BLOCK_WORDS = 8;
  localparam logic [7:0]  SHA256_PAD_BYTE    = 8'h80;
  localparam int          SHA256_LEN_W       = 64;

  // A whole word carrying only the terminator byte in its first byte lane.
  localparam logic [63:0] SHA256_PAD_WORD    = {SHA256_PAD_BYTE, 56'd0};

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT,
    ST_DONE
  } pad_state_t;

endpackage

// File: rtl/sha256_pad_word_gen.sv
// Combinational last-word formatter.
// Keeps the first nbytes bytes of data (byte 0 in [63:56]), zeroes the rest
// and, when insert_pad is set, places the 0x80 terminator at byte nbytes.
// nbytes above 8 is treated as 8.
//   data       in  64  raw message word
//   nbytes     in  4   valid bytes, 0..8
//   insert_pad in  1   place the terminator directly after the valid bytes
//   word       out 64  masked/padded word
module sha256_pad_word_gen
  import sha256_msg_padder_pkg::*;
(
  input  logic [63:0] data,
  input  logic [3:0]  nbytes,
  input  logic        insert_pad,
  output logic [63:0] word
);

  logic [3:0] n_eff;
  assign n_eff = (nbytes > 4'd8) ? 4'd8 : nbytes;

  for (genvar gi = 0; gi < 8; gi++) begin : g_byte
    localparam logic [3:0] POS = 4'(gi);
    assign word[63-8*gi -: 8] = (POS < n_eff)                 ? data[63-8*gi -: 8] :
                                (insert_pad && (POS == n_eff)) ? SHA256_PAD_BYTE    :
                                                                 8'h00;
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder / block sequencer.
// Accepts a 64-bit word stream, applies 0x80 + zero fill + 64-bit bit length,
// assembles 512-bit blocks and drives the core's init/next/ready protocol.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    word handshake; in_data byte 0 in [63:56]
//   in_last, in_nbytes   final-word marker and its valid byte count (0..8)
//   core_init/core_next  one-cycle block start pulses (first / later blocks)
//   core_block           512-bit block, word 0 in [511:448]
//   core_ready           core idle
//   msg_done             one-cycle pulse, final block hashed
//   busy                 message in progress
module sha256_msg_padder
  import sha256_msg_padder_pkg::*;
#(
  parameter int GUARD_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic         in_last,
  input  logic [3:0]   in_nbytes,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  input  logic         core_ready,
  output logic         msg_done,
  output logic         busy
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  pad_state_t              state_reg;
  logic [3:0]              idx_reg;       // next slot to write, 0..8
  logic [SHA256_LEN_W-1:0] len_reg;       // message length in bits, wraps
  logic                    first_reg;     // next issued block is the first
  logic                    final_reg;     // block in flight carries the length
  logic                    pend_reg;      // terminator still owed (last word was full)
  logic                    pad_done_reg;  // terminator placed with room left for length
  logic                    resume_reg;    // after the core finishes, keep padding
  logic [GW-1:0]           guard_reg;
  logic                    init_reg, next_reg, done_reg;
  logic [63:0]             slot_reg [SHA256_BLOCK_WORDS];

  logic [3:0]  nb_clamped;
  logic [63:0] last_word;

  assign nb_clamped = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;

  sha256_pad_word_gen u_word_gen (
    .data       (in_data),
    .nbytes     (nb_clamped),
    .insert_pad (nb_clamped != 4'd8),
    .word       (last_word)
  );

  for (genvar gi = 0; gi < SHA256_BLOCK_WORDS; gi++) begin : g_block
    assign core_block[511-64*gi -: 64] = slot_reg[gi];
  end

  // Gated by rst_n so the port reads 0 for the whole reset period.
  assign in_ready  = rst_n && (state_reg == ST_FILL);
  assign busy      = !((state_reg == ST_FILL) && (idx_reg == 4'd0) && first_reg);
  assign core_init = init_reg;
  assign core_next = next_reg;
  assign msg_done  = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_FILL;
      idx_reg      <= 4'd0;
      len_reg      <= '0;
      first_reg    <= 1'b1;
      final_reg    <= 1'b0;
      pend_reg     <= 1'b0;
      pad_done_reg <= 1'b0;
      resume_reg   <= 1'b0;
      guard_reg    <= '0;
      init_reg     <= 1'b0;
      next_reg     <= 1'b0;
      done_reg     <= 1'b0;
      for (int i = 0; i < SHA256_BLOCK_WORDS; i++) slot_reg[i] <= '0;
    end else begin
      init_reg <= 1'b0;
      next_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_FILL: begin
          if (in_valid) begin
            idx_reg <= idx_reg + 4'd1;
            if (in_last) begin
              slot_reg[idx_reg[2:0]] <= last_word;
              len_reg      <= len_reg + {57'd0, nb_clamped, 3'd0};
              pend_reg     <= (nb_clamped == 4'd8);
              // A terminator in slot 7 leaves no room for the length.
              pad_done_reg <= (nb_clamped != 4'd8) && (idx_reg != 4'd7);
              state_reg    <= ST_PAD;
            end else begin
              slot_reg[idx_reg[2:0]] <= in_data;
              len_reg <= len_reg + 64'd64;
              if (idx_reg == 4'd7) begin
                final_reg  <= 1'b0;
                resume_reg <= 1'b0;
                state_reg  <= ST_ISSUE;
              end
            end
          end
        end
        ST_PAD: begin
          if (idx_reg == 4'd8) begin
            // Block full before the length fit: hash it, then pad a fresh block.
            final_reg  <= 1'b0;
            resume_reg <= 1'b1;
            state_reg  <= ST_ISSUE;
          end else if (pend_reg) begin
            slot_reg[idx_reg[2:0]] <= SHA256_PAD_WORD;
            pend_reg     <= 1'b0;
            pad_done_reg <= (idx_reg != 4'd7);
            idx_reg      <= idx_reg + 4'd1;
          end else if ((idx_reg == 4'd7) && pad_done_reg) begin
            slot_reg[7] <= len_reg;
            final_reg   <= 1'b1;
            resume_reg  <= 1'b0;
            state_reg   <= ST_ISSUE;
          end else begin
            slot_reg[idx_reg[2:0]] <= '0;
            idx_reg <= idx_reg + 4'd1;
          end
        end
        ST_ISSUE: begin
          if (core_ready) begin
            if (first_reg) init_reg <= 1'b1;
            else           next_reg <= 1'b1;
            first_reg <= 1'b0;
            guard_reg <= GW'(GUARD_CYCLES - 1);
            state_reg <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          // core_ready may still read high right after the pulse.
          if (guard_reg == '0) state_reg <= ST_WAIT;
          else                 guard_reg <= guard_reg - GW'(1);
        end
        ST_WAIT: begin
          if (core_ready) begin
            if (final_reg) begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              idx_reg <= 4'd0;
              if (resume_reg) begin
                // Terminator already emitted (or owed via pend_reg): the
                // fresh block ends in the length word.
                pad_done_reg <= 1'b1;
                resume_reg   <= 1'b0;
                state_reg    <= ST_PAD;
              end else begin
                state_reg <= ST_FILL;
              end
            end
          end
        end
        ST_DONE: begin
          len_reg      <= '0;
          first_reg    <= 1'b1;
          final_reg    <= 1'b0;
          pend_reg     <= 1'b0;
          pad_done_reg <= 1'b0;
          idx_reg      <= 4'd0;
          state_reg    <= ST_FILL;
        end
        default: state_reg <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Testbench for sha256_msg_padder: random and directed messages, a
// behavioural SHA-256 core model, and a byte-level padding reference.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_last;
  logic [63:0]  in_data;
  logic [3:0]   in_nbytes;
  logic         core_init, core_next, core_ready, msg_done, busy;
  logic [511:0] core_block;

  always #5 clk = ~clk;

  sha256_msg_padder #(.GUARD_CYCLES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_nbytes  (in_nbytes),
    .core_init  (core_init),
    .core_next  (core_next),
    .core_block (core_block),
    .core_ready (core_ready),
    .msg_done   (msg_done),
    .busy       (busy)
  );

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // ---------------- core model ----------------
  logic [255:0] h_reg;
  logic         core_busy;
  int           busy_cnt;
  logic         stall;
  int           core_lat;
  logic         stable_bad   = 1'b0;
  logic         protocol_bad = 1'b0;
  logic [511:0] cap_q [$];
  bit           cap_init_q [$];
  int           done_cnt = 0;

  assign core_ready = !core_busy && !stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy <= 1'b0;
      busy_cnt  <= 0;
    end else if (core_init || core_next) begin
      if ((core_init && core_next) || !core_ready) protocol_bad <= 1'b1;
      cap_q.push_back(core_block);
      cap_init_q.push_back(core_init);
      h_reg     <= sha_compress(core_init ? IV : h_reg, core_block);
      core_busy <= 1'b1;
      busy_cnt  <= core_lat;
    end else if (core_busy) begin
      if (core_block !== cap_q[$]) stable_bad <= 1'b1;
      if (busy_cnt == 0) core_busy <= 1'b0;
      else               busy_cnt  <= busy_cnt - 1;
    end
  end

  always @(posedge clk) if (msg_done) done_cnt <= done_cnt + 1;

  // ---------------- reference and checking ----------------
  int checks = 0;
  int errors = 0;
  byte unsigned msg [$];
  logic [511:0] exp_blk [$];
  int cap_base, done_base;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIPS 180-4 padding on the byte level, split into 64-byte blocks.
  task automatic build_exp();
    byte unsigned p [$];
    longint unsigned bits;
    logic [511:0] b;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = longint'(msg.size()) * 8;
    for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
    exp_blk.delete();
    for (int j = 0; j < p.size() / 64; j++) begin
      b = '0;
      for (int i = 0; i < 64; i++) b[511-8*i -: 8] = p[64*j+i];
      exp_blk.push_back(b);
    end
    cap_base  = cap_q.size();
    done_base = done_cnt;
  endtask

  task automatic new_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    build_exp();
  endtask

  task automatic set_abc();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    build_exp();
  endtask

  // Sends up to max_words words of msg; returns at the negedge after the
  // last handshake, leaving that word on the bus.
  task automatic drive(input int max_words);
    int nw, nb, t;
    bit last;
    logic [63:0] d;
    nw = (msg.size() + 7) / 8;
    if (nw == 0) nw = 1;
    for (int w = 0; w < nw && w < max_words; w++) begin
      last = (w == nw - 1);
      nb   = last ? msg.size() - 8 * w : 8;
      d    = {$urandom, $urandom};
      for (int bi = 0; bi < 8; bi++) if (bi < nb) d[63-8*bi -: 8] = msg[8*w+bi];
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      if (!last)                                in_nbytes = 4'($urandom);
      else if (nb == 8 && $urandom_range(0, 1)) in_nbytes = 4'($urandom_range(9, 15));
      else                                      in_nbytes = 4'(nb);
      t = 0;
      while (!in_ready && t < 500) begin @(negedge clk); t++; end
      chk("in_ready_wait", in_ready, 1);
      @(negedge clk);
    end
  endtask

  task automatic finish(input string tag);
    int t;
    bit ready_bad;
    t = 0;
    ready_bad = 0;
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_data  = {$urandom, $urandom};
    while (!msg_done && t < 3000) begin
      if (in_ready) ready_bad = 1;
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    chk({tag, "_msg_done"}, msg_done, 1);
    chk({tag, "_no_accept"}, ready_bad, 0);
    @(negedge clk);
    chk({tag, "_done_pulse_len"}, msg_done, 0);
    chk({tag, "_done_count"}, done_cnt - done_base, 1);
    chk({tag, "_nblocks"}, cap_q.size() - cap_base, exp_blk.size());
    for (int i = 0; i < exp_blk.size(); i++) begin
      chk($sformatf("%s_blk%0d", tag, i), cap_q[cap_base+i], exp_blk[i]);
      chk($sformatf("%s_kind%0d", tag, i), cap_init_q[cap_base+i], (i == 0));
    end
    chk({tag, "_block_stable"}, stable_bad, 0);
    chk({tag, "_protocol"}, protocol_bad, 0);
    $display("msg %s bytes=%0d blocks=%0d checks=%0d errors=%0d", tag, msg.size(), exp_blk.size(), checks, errors);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_core_init"}, core_init, 0);
    chk({tag, "_core_next"}, core_next, 0);
    chk({tag, "_msg_done"}, msg_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_core_block"}, core_block, 0);
  endtask

  initial begin
    int t;
    bit pulse_seen, blk_moved;
    logic [511:0] snap;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0;
    stall = 1'b0; core_lat = 3;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_busy", busy, 0);
    @(negedge clk);

    set_abc();   drive(99); finish("abc");   chk("abc_digest", h_reg, DIG_ABC);
    new_msg(0);  drive(99); finish("empty"); chk("empty_digest", h_reg, DIG_EMPTY);
    new_msg(56); drive(99); finish("len56");
    new_msg(64); drive(99); finish("len64");

    for (int r = 0; r < 8; r++) begin
      core_lat = $urandom_range(0, 6);
      new_msg($urandom_range(0, 150));
      drive(99);
      finish($sformatf("rand%0d", r));
    end
    core_lat = 3;

    // core_ready held low at ISSUE
    stall = 1'b1;
    set_abc();
    drive(99);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    snap = core_block;
    chk("stall_block_content", snap, exp_blk[0]);
    pulse_seen = 0; blk_moved = 0;
    repeat (20) begin
      if (core_init || core_next) pulse_seen = 1;
      if (core_block !== snap) blk_moved = 1;
      @(negedge clk);
    end
    chk("stall_no_pulse", pulse_seen, 0);
    chk("stall_block_stable", blk_moved, 0);
    stall = 1'b0;
    @(negedge clk);
    chk("stall_init_on_ready", core_init, 1);
    finish("stall_abc");
    chk("stall_abc_digest", h_reg, DIG_ABC);
    new_msg(0); drive(99); finish("b2b_empty"); chk("b2b_empty_digest", h_reg, DIG_EMPTY);

    // reset in FILL with four words stored
    new_msg(60);
    drive(4);
    chk("fill4_busy", busy, 1);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check_reset_outputs("rst_fill");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_fill_release_ready", in_ready, 1);
    @(negedge clk);
    set_abc(); drive(99); finish("after_rst_fill"); chk("after_rst_fill_digest", h_reg, DIG_ABC);

    // reset while waiting on a slow core
    core_lat = 40;
    new_msg(20);
    drive(99);
    in_valid = 1'b0;
    t = 0;
    while (!core_init && t < 200) begin @(negedge clk); t++; end
    chk("slow_saw_init", core_init, 1);
    repeat (5) @(negedge clk);
    chk("slow_wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    core_lat = 3;
    @(negedge clk);
    new_msg(100); drive(99); finish("after_rst_wait");
    set_abc();    drive(99); finish("after_rst_wait_abc"); chk("after_rst_wait_digest", h_reg, DIG_ABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
